ip_rx_arbiter: RTL

Frame-level round-robin arbiter that shares one `ip_parser` instance between two receive byte-stream sources, e.g. two MAC receive FIFOs. It grants one source per frame and forwards its bytes on the `ip_parser` input signals. It paces bytes to a programmable rate. A source that stalls mid-frame is aborted with an error pulse, and the rest of that frame is drained so the shared parser is never blocked.

---
 rtl/ip_rx_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ip_rx_arbiter.sv
// ip_rx_arbiter
// Frame-level round-robin arbiter that shares one ip_parser between two
// receive byte streams. One source is granted per frame and its bytes are
// forwarded to the parser at most one per BYTE_GAP+1 cycles. A granted
// source that stalls mid-frame for TIMEOUT cycles is aborted with an
// eof+err pulse, and the rest of its frame is drained and discarded.
//
// Parameters:
//   BYTE_GAP       idle cycles forced after every accepted byte
//   TIMEOUT        consecutive mid-frame stall cycles before abort (0 = off)
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   s0_*, s1_*     source streams (tdata/tvalid/tlast/tuser in, tready out)
//   eth_data_in    byte to ip_parser
//   eth_byte_valid one-cycle pulse per forwarded byte
//   eth_eof        end of frame (last byte, or abort)
//   eth_err        frame error (tuser on tlast) or abort
//   src_port       granted source, held until the next grant
//   busy           high while a frame is being forwarded or drained
//   timeout_count  saturating count of aborts

package ip_rx_arbiter_pkg;
    typedef logic [7:0] byte_t;
endpackage

module ip_rx_arbiter
    import ip_rx_arbiter_pkg::*;
#(
    parameter int BYTE_GAP = 0,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  byte_t       s0_tdata,
    input  logic        s0_tvalid,
    input  logic        s0_tlast,
    input  logic        s0_tuser,
    output logic        s0_tready,
    input  byte_t       s1_tdata,
    input  logic        s1_tvalid,
    input  logic        s1_tlast,
    input  logic        s1_tuser,
    output logic        s1_tready,
    output byte_t       eth_data_in,
    output logic        eth_byte_valid,
    output logic        eth_eof,
    output logic        eth_err,
    output logic        src_port,
    output logic        busy,
    output logic [15:0] timeout_count
);

    localparam int GAP_W   = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
    localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, FWD, DRAIN} state_t;

    state_t             state, state_n;
    logic               last_grant, last_grant_n;
    logic               src_port_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [STALL_W-1:0] stall_cnt, stall_n;
    byte_t              data_n;
    logic               bv_n, eof_n, err_n;
    logic [15:0]        tcount_n;

    // Mux of the granted source's signals.
    byte_t sel_data;
    logic  sel_valid, sel_last, sel_user;
    logic  accept, hs, grant;

    assign sel_data  = src_port ? s1_tdata  : s0_tdata;
    assign sel_valid = src_port ? s1_tvalid : s0_tvalid;
    assign sel_last  = src_port ? s1_tlast  : s0_tlast;
    assign sel_user  = src_port ? s1_tuser  : s0_tuser;

    // Ready depends only on registered state, so it is glitch-free and
    // never combinationally follows tvalid.
    assign accept    = (state == DRAIN) || (state == FWD && gap_cnt == '0);
    assign s0_tready = accept && !src_port;
    assign s1_tready = accept &&  src_port;
    assign hs        = accept && sel_valid;
    assign busy      = (state != IDLE);

    // Both requesting: the port that did not win last time. Otherwise the
    // single requester (s1_tvalid alone selects port 1).
    assign grant = (s0_tvalid && s1_tvalid) ? !last_grant : s1_tvalid;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_n      = state;
        last_grant_n = last_grant;
        src_port_n   = src_port;
        gap_n        = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : gap_cnt;
        stall_n      = stall_cnt;
        data_n       = '0;
        bv_n         = 1'b0;
        eof_n        = 1'b0;
        err_n        = 1'b0;
        tcount_n     = timeout_count;

        case (state)
            IDLE: begin
                // Byte pacing never carries over into the next frame.
                gap_n   = '0;
                stall_n = '0;
                if (s0_tvalid || s1_tvalid) begin
                    src_port_n   = grant;
                    last_grant_n = grant;
                    state_n      = FWD;
                end
            end
            FWD: begin
                if (hs) begin
                    data_n  = sel_data;
                    bv_n    = 1'b1;
                    eof_n   = sel_last;
                    err_n   = sel_last && sel_user;
                    gap_n   = GAP_W'(BYTE_GAP);
                    stall_n = '0;
                    if (sel_last) state_n = IDLE;
                end else if (gap_cnt == '0 && TIMEOUT != 0) begin
                    // Ready but nothing offered: a stall cycle.
                    if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                        eof_n   = 1'b1;
                        err_n   = 1'b1;
                        stall_n = '0;
                        state_n = DRAIN;
                        if (timeout_count != 16'hFFFF)
                            tcount_n = timeout_count + 16'd1;
                    end else begin
                        stall_n = stall_cnt + STALL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (hs && sel_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            src_port       <= 1'b0;
            gap_cnt        <= '0;
            stall_cnt      <= '0;
            eth_data_in    <= '0;
            eth_byte_valid <= 1'b0;
            eth_eof        <= 1'b0;
            eth_err        <= 1'b0;
            timeout_count  <= '0;
        end else begin
            state          <= state_n;
            last_grant     <= last_grant_n;
            src_port       <= src_port_n;
            gap_cnt        <= gap_n;
            stall_cnt      <= stall_n;
            eth_data_in    <= data_n;
            eth_byte_valid <= bv_n;
            eth_eof        <= eof_n;
            eth_err        <= err_n;
            timeout_count  <= tcount_n;
        end
    end

endmodule
